alu_share_ctrl: RTL and testbench

Shares one 4-bit, 4-operation ALU datapath (add, sub, and, or) between two requesters. Round-robin arbitration picks a requester and a valid/ready handshake accepts its operation. The block registers the operands, drives the shared ALU, captures the result and returns it with the requester ID over a response handshake that supports backpressure. It sits between the requester logic and the ALU top and is the only driver of the ALU inputs.

---
 rtl/alu_share_ctrl.sv | 135 +++++++++++++
 tb/tb_alu_share_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
`timescale 1ns/1ps
// alu_share_ctrl: round-robin front end that lets two requesters share one
// small ALU. An accepted operation is registered onto the ALU inputs and
// given one cycle to settle. The result is then held on a response
// handshake until the consumer takes it.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | arbitrating; at most one requester sees ready
// EXEC  | ALU inputs registered and stable, result settling
// RESP  | result captured, rsp_valid held until rsp_ready
module alu_share_ctrl #(
    parameter int WIDTH = 4,
    parameter int OPW   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic             last_grant_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [OPW-1:0]   alu_op_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_data_q;

    logic             grant_d;
    logic             accept_d;
    logic [WIDTH-1:0] sel_a_d;
    logic [WIDTH-1:0] sel_b_d;
    logic [OPW-1:0]   sel_op_d;

    // Round-robin pick: a lone requester wins outright, a tie goes to the
    // requester that was not served last.
    always_comb begin
        grant_d = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_d = ~last_grant_q;
        end else if (req1_valid) begin
            grant_d = 1'b1;
        end
    end

    assign req0_ready = (state_q == IDLE) && req0_valid && (grant_d == 1'b0);
    assign req1_ready = (state_q == IDLE) && req1_valid && (grant_d == 1'b1);

    // Payload of the granted requester, plus whether a handshake happens now.
    always_comb begin
        accept_d = req0_ready || req1_ready;
        sel_a_d  = req0_a;
        sel_b_d  = req0_b;
        sel_op_d = req0_op;
        if (grant_d) begin
            sel_a_d  = req1_a;
            sel_b_d  = req1_b;
            sel_op_d = req1_op;
        end
    end

    // Sequencer with registered ALU-side and response-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        alu_a_q      <= sel_a_d;
                        alu_b_q      <= sel_b_d;
                        alu_op_q     <= sel_op_d;
                        rsp_id_q     <= grant_d;
                        last_grant_q <= grant_d;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_q  <= alu_result;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
`timescale 1ns/1ps
// Bench for alu_share_ctrl: a behavioural ALU closes the loop, requesters
// are modelled as op counters, and expected (id, data) pairs are queued by
// the test sequence and popped on each response handshake.
module tb_alu_share_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0;
    logic       req0_ready;
    logic [3:0] req0_a = '0;
    logic [3:0] req0_b = '0;
    logic [1:0] req0_op = '0;
    logic       req1_valid = 1'b0;
    logic       req1_ready;
    logic [3:0] req1_a = '0;
    logic [3:0] req1_b = '0;
    logic [1:0] req1_op = '0;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_op;
    logic [3:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic       rsp_id;
    logic [3:0] rsp_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [4:0] exp_q[$];
    int  n0 = 0, n1 = 0;
    logic hs0 = 1'b0, hs1 = 1'b0;
    int  cyc = 0;
    int  accept_cyc = 0;
    int  rdy0_cnt = 0;
    int  last1 = -1;
    logic b2b_on = 1'b0;
    logic rsp_valid_prev = 1'b0;

    alu_share_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_op)
            2'b00:   alu_result = alu_a + alu_b;
            2'b01:   alu_result = alu_a - alu_b;
            2'b10:   alu_result = alu_a & alu_b;
            default: alu_result = alu_a | alu_b;
        endcase
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (exp_q.size() != 0 || n0 != 0 || n1 != 0); i++) tick();
        chk("drain_left", exp_q.size(), 0);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    always @(posedge clk) cyc++;

    // Response monitor, handshake sampling and latency/fairness timing.
    always @(negedge clk) begin
        logic [4:0] e;
        hs0 = req0_valid && req0_ready && !rst;
        hs1 = req1_valid && req1_ready && !rst;
        if (req0_ready || req1_ready) chk("ready_onehot", int'(req0_ready & req1_ready), 0);
        if (req0_ready && !rst) rdy0_cnt++;
        if (hs1 && b2b_on) begin
            if (last1 >= 0) chk("b2b_gap", cyc - last1, 3);
            last1 = cyc;
        end
        if (hs0 || hs1) accept_cyc = cyc;
        if (rsp_valid && !rsp_valid_prev) chk("latency", cyc - accept_cyc, 2);
        rsp_valid_prev = rsp_valid;
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_id", int'(rsp_id), int'(e[4]));
                chk("rsp_data", int'(rsp_data), int'(e[3:0]));
            end
        end
    end

    // Requester model: each holds valid until its remaining op count is used up.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hs0 && n0 > 0) n0--;
            if (hs1 && n1 > 0) n1--;
            req0_valid = (n0 > 0);
            req1_valid = (n1 > 0);
        end
    end

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_alu_a", int'(alu_a), 0);
        chk("rst_alu_op", int'(alu_op), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        chk("rst_ready0", int'(req0_ready), 0);
        tick();

        // Single add on requester 0.
        rdy0_cnt = 0;
        req0_a = 4'd3; req0_b = 4'd5; req0_op = 2'b00;
        exp_q.push_back({1'b0, 4'd8});
        n0 = 1;
        drain(40);
        chk("ready0_cycles", rdy0_cnt, 1);

        // Both requesters held valid: grants must alternate starting at 0.
        do_reset();
        req0_a = 4'd9; req0_b = 4'd3; req0_op = 2'b01;
        req1_a = 4'hC; req1_b = 4'hA; req1_op = 2'b10;
        exp_q.push_back({1'b0, 4'd6});
        exp_q.push_back({1'b1, 4'd8});
        exp_q.push_back({1'b0, 4'd6});
        exp_q.push_back({1'b1, 4'd8});
        n0 = 2; n1 = 2;
        drain(80);

        // Wrap-around results and op passthrough via requester 1.
        req1_a = 4'hF; req1_b = 4'h1; req1_op = 2'b00;
        exp_q.push_back({1'b1, 4'h0}); n1 = 1; drain(40);
        req1_a = 4'h0; req1_b = 4'h1; req1_op = 2'b01;
        exp_q.push_back({1'b1, 4'hF}); n1 = 1; drain(40);
        req1_a = 4'h5; req1_b = 4'hA; req1_op = 2'b11;
        exp_q.push_back({1'b1, 4'hF}); n1 = 1; drain(40);

        // Backpressure: response frozen, nothing accepted, then release.
        rsp_ready = 1'b0;
        req0_a = 4'd7; req0_b = 4'd2; req0_op = 2'b00;
        req1_a = 4'd4; req1_b = 4'd4; req1_op = 2'b00;
        exp_q.push_back({1'b0, 4'd9});
        exp_q.push_back({1'b1, 4'd8});
        n0 = 1; n1 = 1;
        for (int i = 0; i < 20 && !rsp_valid; i++) tick();
        chk("bp_valid_seen", int'(rsp_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", int'(rsp_valid), 1);
            chk("bp_data", int'(rsp_data), 9);
            chk("bp_id", int'(rsp_id), 0);
            chk("bp_ready1", int'(req1_ready), 0);
            chk("bp_ready0", int'(req0_ready), 0);
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_next_accept", int'(req1_ready), 1);
        drain(40);

        // Reset while in EXEC: response dropped, arbitration pointer restored.
        req0_a = 4'd1; req0_b = 4'd1; req0_op = 2'b00;
        n0 = 1;
        for (int i = 0; i < 20 && !hs0; i++) @(negedge clk);
        chk("mid_accept_seen", int'(hs0), 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_alu_a", int'(alu_a), 0);
        chk("mid_alu_b", int'(alu_b), 0);
        chk("mid_alu_op", int'(alu_op), 0);
        chk("mid_rsp_valid", int'(rsp_valid), 0);
        chk("mid_rsp_id", int'(rsp_id), 0);
        chk("mid_rsp_data", int'(rsp_data), 0);
        tick();
        rst = 1'b0;
        repeat (8) tick();
        req0_a = 4'd1; req0_b = 4'd2; req0_op = 2'b00;
        req1_a = 4'd6; req1_b = 4'd2; req1_op = 2'b01;
        exp_q.push_back({1'b0, 4'd3});
        exp_q.push_back({1'b1, 4'd4});
        n0 = 1; n1 = 1;
        drain(40);

        // Lone requester 1 served back-to-back every 3 cycles.
        b2b_on = 1'b1;
        last1 = -1;
        req1_a = 4'd2; req1_b = 4'd3; req1_op = 2'b00;
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 4'd5});
        n1 = 4;
        drain(60);
        b2b_on = 1'b0;
        chk("b2b_last_seen", int'(last1 >= 0), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
